mem_dbus_ctrl: RTL and testbench
================================

# mem_dbus_ctrl

MEM-stage data-bus controller on the consuming side of the EX→MEM pipeline register. It turns the latched load/store request (read/write flags, memory op, address, store data) into a single SRAM-like data-bus transaction, raises a pipeline stall request while that transaction is in flight, and extracts and extends the load result. It detects misaligned addresses (AdEL/AdES) before issuing, and discards the response of an access that is in flight when a flush arrives.

## Interface
- No parameters.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  exception/eret flush of the MEM stage.
- stall_i  in  1  the pipeline is held by any source (includes this block's own request).
- mem_rmem_i  in  1  the latched instruction is a load.
- mem_wmem_i  in  1  the latched instruction is a store.
- mem_op_i  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW.
- mem_addr_i  in  32  effective address.
- mem_wdata_i  in  32  store source register (rt) value.
- data_req_o  out  1  bus request.
- data_wr_o  out  1  1=write.
- data_size_o  out  2  0=byte 1=half 2=word.
- data_addr_o  out  32  equals mem_addr_i.
- data_wdata_o  out  32  store data replicated per lane (SB: {4{b}}, SH: {2{h}}).
- data_addr_ok_i  in  1  request accepted.
- data_data_ok_i  in  1  response (read data or write ack).
- data_rdata_i  in  32  read data word.
- stall_req_o  out  1  hold the pipeline.
- load_data_o  out  32  aligned and extended load result.
- exc_adel_o  out  1  load address error.
- exc_ades_o  out  1  store address error.
- badvaddr_o  out  32  faulting address (equals mem_addr_i).

## Operation
- access = (mem_rmem_i | mem_wmem_i) & ~flush_i. Misalignment: half ops with addr[0]=1, word ops with addr[1:0]≠0. exc_adel_o = access & load & misaligned; exc_ades_o likewise for stores. Both are combinational; a misaligned access never issues a request and never stalls.
- FSM with states IDLE, REQ, WAIT, DONE, CANCEL:
  - IDLE: on an aligned access, go to REQ.
  - REQ: data_req_o=1. On addr_ok&data_ok go to DONE; on addr_ok alone go to WAIT; on flush_i without addr_ok go to IDLE (request withdrawn).
  - WAIT: on data_ok go to DONE. On flush_i without data_ok go to CANCEL. If flush_i and data_ok arrive together, go to IDLE and discard the data.
  - DONE: the transaction has completed. Stay in DONE while stall_i=1, so the held instruction is never reissued. Go to IDLE when stall_i=0 or on flush_i.
  - CANCEL: wait for data_ok, discard the data, then go to IDLE.
- stall_req_o = (IDLE & aligned access) | REQ | WAIT | (CANCEL & access). It is 0 in DONE.
- Load data is captured into a register on data_ok when not cancelled. load_data_o is computed combinationally from the captured word using mem_addr_i[1:0] (little-endian lane select):
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- data_size_o, data_wr_o and data_wdata_o are derived from mem_op_i and are valid whenever data_req_o=1.

## Timing
- Reset values: state IDLE, captured data 0, data_req_o 0, stall_req_o 0, load_data_o 0. The exception outputs follow their inputs.
- Minimum access latency:
  - Request is driven in cycle 1 (REQ).
  - addr_ok and data_ok arrive in cycle 1.
  - DONE in cycle 2, where stall_req_o=0 and load_data_o is valid.
  - The pipeline advances at the end of cycle 2.
- data_req_o and its payload are held stable from the REQ entry until addr_ok. The only exception is a flush before addr_ok.
- Only one outstanding transaction exists at a time; the bus is never re-requested until a data_ok has been seen for the last accepted request.
- Asserting reset mid-transaction forces IDLE immediately. Bus-side recovery is the interconnect's responsibility.

## Test plan
- LW at 0x1000, with addr_ok in cycle 1 and data_ok in cycle 3 returning 0x8899AABB → stall_req_o=1 for cycles 0–3, load_data_o=0x8899AABB, exactly one request.
- LB at addr 0x1003, rdata 0x80112233 → 0xFFFFFF80. LBU gives 0x00000080. LH at 0x1002 gives 0xFFFF8011.
- SH at 0x2002 with rt=0x0000BEEF → data_wr_o=1, data_size_o=1, data_wdata_o=0xBEEFBEEF, and exactly one request.
- LW at 0x1001 → exc_adel_o=1, badvaddr_o=0x1001, with no request and no stall. SH at 0x2001 → exc_ades_o=1.
- Flush during WAIT, then a new LW arriving before the stale data_ok → the stale data is discarded, and the new request is issued only after that data_ok.
- A completed access that remains in DONE with stall_i=1 for 5 cycles → no reissue, and load_data_o stays stable.

Source files
------------

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller: issues one SRAM-like bus transaction per load/store,
// stalls the pipeline while it is in flight, and aligns/extends the load result.
module mem_dbus_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        mem_rmem_i,
    input  logic        mem_wmem_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i,
    output logic        stall_req_o,
    output logic [31:0] load_data_o,
    output logic        exc_adel_o,
    output logic        exc_ades_o,
    output logic [31:0] badvaddr_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_CANCEL = 3'd4;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [31:0] rdata_q;
    logic        access;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        aligned_access;
    logic        capture;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign access         = (mem_rmem_i | mem_wmem_i) & ~flush_i;
    assign is_half        = (mem_op_i == OP_LH) | (mem_op_i == OP_LHU) | (mem_op_i == OP_SH);
    assign is_word        = (mem_op_i == OP_LW) | (mem_op_i == OP_SW);
    assign misaligned     = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
    assign aligned_access = access & ~misaligned;

    assign exc_adel_o = access & mem_rmem_i & misaligned;
    assign exc_ades_o = access & mem_wmem_i & misaligned;
    assign badvaddr_o = mem_addr_i;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (aligned_access) state_next = ST_REQ;
            ST_REQ: begin
                if (data_addr_ok_i) begin
                    if (data_data_ok_i) state_next = flush_i ? ST_IDLE : ST_DONE;
                    else                state_next = flush_i ? ST_CANCEL : ST_WAIT;
                end else if (flush_i) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (data_data_ok_i) state_next = flush_i ? ST_IDLE : ST_DONE;
                else if (flush_i)   state_next = ST_CANCEL;
            end
            // Holding in DONE while stalled keeps the same instruction from being reissued.
            ST_DONE:   if (!stall_i || flush_i) state_next = ST_IDLE;
            ST_CANCEL: if (data_data_ok_i) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign capture = data_data_ok_i & ~flush_i &
                     (((state == ST_REQ) & data_addr_ok_i) | (state == ST_WAIT));

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= ST_IDLE;
            rdata_q <= 32'h0;
        end else begin
            state <= state_next;
            if (capture) rdata_q <= data_rdata_i;
        end
    end

    assign data_req_o  = (state == ST_REQ);
    assign data_addr_o = mem_addr_i;
    assign data_wr_o   = (mem_op_i == OP_SB) | (mem_op_i == OP_SH) | (mem_op_i == OP_SW);
    assign stall_req_o = ((state == ST_IDLE) & aligned_access) | (state == ST_REQ) |
                         (state == ST_WAIT) | ((state == ST_CANCEL) & access);

    always_comb begin
        data_size_o  = 2'd2;
        data_wdata_o = mem_wdata_i;
        case (mem_op_i)
            OP_LB, OP_LBU: data_size_o = 2'd0;
            OP_LH, OP_LHU: data_size_o = 2'd1;
            OP_SB: begin
                data_size_o  = 2'd0;
                data_wdata_o = {4{mem_wdata_i[7:0]}};
            end
            OP_SH: begin
                data_size_o  = 2'd1;
                data_wdata_o = {2{mem_wdata_i[15:0]}};
            end
            default: data_size_o = 2'd2;
        endcase
    end

    // Little-endian lane select from the captured word.
    always_comb begin
        case (mem_addr_i[1:0])
            2'd0:    lane_byte = rdata_q[7:0];
            2'd1:    lane_byte = rdata_q[15:8];
            2'd2:    lane_byte = rdata_q[23:16];
            default: lane_byte = rdata_q[31:24];
        endcase
        lane_half = mem_addr_i[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (mem_op_i)
            OP_LB:   load_data_o = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  load_data_o = {24'h0, lane_byte};
            OP_LH:   load_data_o = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  load_data_o = {16'h0, lane_half};
            default: load_data_o = rdata_q;
        endcase
    end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Self-checking bench for mem_dbus_ctrl: directed plan cases, flush/reset corners and
// randomized accesses checked against a byte-lane arithmetic reference model.
module tb_mem_dbus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        hold;
    logic        stall;
    logic        rmem;
    logic        wmem;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        stall_req;
    logic [31:0] load_data;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] badvaddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign stall = stall_req | hold;

    mem_dbus_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .flush_i        (flush),
        .stall_i        (stall),
        .mem_rmem_i     (rmem),
        .mem_wmem_i     (wmem),
        .mem_op_i       (op),
        .mem_addr_i     (addr),
        .mem_wdata_i    (wdata),
        .data_req_o     (data_req),
        .data_wr_o      (data_wr),
        .data_size_o    (data_size),
        .data_addr_o    (data_addr),
        .data_wdata_o   (data_wdata),
        .data_addr_ok_i (addr_ok),
        .data_data_ok_i (data_ok),
        .data_rdata_i   (rdata),
        .stall_req_o    (stall_req),
        .load_data_o    (load_data),
        .exc_adel_o     (exc_adel),
        .exc_ades_o     (exc_ades),
        .badvaddr_o     (badvaddr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes-log2, lane arithmetic, sign rules.
    function automatic int ref_size(input logic [2:0] o);
        if (o == 3'd0 || o == 3'd1 || o == 3'd5) return 0;
        if (o == 3'd2 || o == 3'd3 || o == 3'd6) return 1;
        return 2;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] o, input logic [31:0] a);
        int sz = ref_size(o);
        return (a % (1 << sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b = (w >> (8 * (a % 4))) & 32'hFF;
        logic [31:0] h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (o)
            3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return b;
            3'd2:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd3:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] o, input logic [31:0] d);
        if (o == 3'd5) return (d & 32'hFF) * 32'h0101_0101;
        if (o == 3'd6) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // Entered and left at posedge+1. Returns the number of stalled cycles before DONE.
    task automatic run_access(input string tag, input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int a_dly, input int d_dly, input int hold_cycles,
                              output int stall_cycles);
        bit is_load = (o <= 3'd4);
        bit mis = ref_misaligned(o, a);
        int n = 0;
        int req_cyc = 0;
        int dwait = 0;
        int reqs = 0;
        bit acc = 0;
        bit done = 0;
        logic [31:0] exp_ld;
        logic [31:0] held;
        stall_cycles = 0;
        rmem = is_load; wmem = !is_load; op = o; addr = a; wdata = wd; rdata = rd;
        #1;
        check({tag, " adel"}, {31'h0, exc_adel}, {31'h0, is_load & mis});
        check({tag, " ades"}, {31'h0, exc_ades}, {31'h0, !is_load & mis});
        if (mis) begin
            check({tag, " badvaddr"}, badvaddr, a);
            check({tag, " mis req"}, {31'h0, data_req}, 32'h0);
            check({tag, " mis stall"}, {31'h0, stall_req}, 32'h0);
            @(posedge clk); #1;
            check({tag, " mis req later"}, {31'h0, data_req}, 32'h0);
            rmem = 1'b0; wmem = 1'b0;
            return;
        end
        while (!done && n < 100) begin
            if (n > 0) #1;
            check({tag, " busy stall"}, {31'h0, stall_req}, 32'h1);
            check({tag, " req level"}, {31'h0, data_req}, {31'h0, (n >= 1) && !acc});
            if (data_req) begin
                check({tag, " wr"}, {31'h0, data_wr}, {31'h0, !is_load});
                check({tag, " size"}, {30'h0, data_size}, ref_size(o));
                check({tag, " addr"}, data_addr, a);
                if (!is_load) check({tag, " wdata"}, data_wdata, ref_wdata(o, wd));
                if (req_cyc == a_dly) begin
                    addr_ok = 1'b1;
                    reqs++;
                    acc = 1;
                    dwait = 0;
                end
                req_cyc++;
            end
            if (acc) begin
                if (dwait == d_dly) begin
                    data_ok = 1'b1;
                    done = 1;
                end
                dwait++;
            end
            stall_cycles++;
            @(posedge clk); #1;
            addr_ok = 1'b0; data_ok = 1'b0;
            n++;
        end
        if (!done) begin
            check({tag, " timeout"}, 32'h0, 32'h1);
            rmem = 1'b0; wmem = 1'b0;
            return;
        end
        hold = (hold_cycles > 0);
        exp_ld = ref_load(o, a, rd);
        rdata = ~rd;
        #1;
        check({tag, " done stall"}, {31'h0, stall_req}, 32'h0);
        check({tag, " done req"}, {31'h0, data_req}, 32'h0);
        check({tag, " one request"}, reqs, 32'h1);
        if (is_load) check({tag, " load"}, load_data, exp_ld);
        held = load_data;
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk); #1;
            if (i == hold_cycles - 1) hold = 1'b0;
            #1;
            check({tag, " hold req"}, {31'h0, data_req}, 32'h0);
            check({tag, " hold stall"}, {31'h0, stall_req}, 32'h0);
            check({tag, " hold load"}, load_data, held);
        end
        @(posedge clk); #1;
        rmem = 1'b0; wmem = 1'b0;
        #1;
        check({tag, " idle stall"}, {31'h0, stall_req}, 32'h0);
        check({tag, " idle req"}, {31'h0, data_req}, 32'h0);
    endtask

    initial begin
        int sc;
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0; rmem = 1'b0; wmem = 1'b0;
        op = 3'd4; addr = 32'h0; wdata = 32'h0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
        #12;
        check("reset req", {31'h0, data_req}, 32'h0);
        check("reset stall", {31'h0, stall_req}, 32'h0);
        check("reset load", load_data, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_access("lw", 3'd4, 32'h1000, 32'h0, 32'h8899_AABB, 0, 2, 0, sc);
        check("lw stall cycles", sc, 32'd4);
        run_access("lb", 3'd0, 32'h1003, 32'h0, 32'h8011_2233, 0, 0, 0, sc);
        run_access("lbu", 3'd1, 32'h1003, 32'h0, 32'h8011_2233, 1, 0, 0, sc);
        run_access("lh", 3'd2, 32'h1002, 32'h0, 32'h8011_2233, 0, 1, 0, sc);
        run_access("sh", 3'd6, 32'h2002, 32'h0000_BEEF, 32'h0, 0, 0, 0, sc);
        run_access("lw mis", 3'd4, 32'h1001, 32'h0, 32'h0, 0, 0, 0, sc);
        run_access("sh mis", 3'd6, 32'h2001, 32'h0, 32'h0, 0, 0, 0, sc);
        run_access("lw hold", 3'd4, 32'h1004, 32'h0, 32'hCAFE_F00D, 1, 1, 5, sc);

        // Flush in WAIT, new LW arrives before the stale response.
        rmem = 1'b1; op = 3'd4; addr = 32'h3000;
        @(posedge clk); #1;
        check("fw req", {31'h0, data_req}, 32'h1);
        addr_ok = 1'b1;
        @(posedge clk); #1;
        addr_ok = 1'b0; flush = 1'b1;
        #1 check("fw wait stall", {31'h0, stall_req}, 32'h1);
        @(posedge clk); #1;
        flush = 1'b0; addr = 32'h3004;
        #1 check("fw cancel req", {31'h0, data_req}, 32'h0);
        check("fw cancel stall", {31'h0, stall_req}, 32'h1);
        @(posedge clk); #1;
        check("fw still cancel", {31'h0, data_req}, 32'h0);
        data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        data_ok = 1'b0; rdata = 32'h1234_5678;
        #1 check("fw idle req", {31'h0, data_req}, 32'h0);
        check("fw idle stall", {31'h0, stall_req}, 32'h1);
        @(posedge clk); #1;
        check("fw new req", {31'h0, data_req}, 32'h1);
        addr_ok = 1'b1; data_ok = 1'b1;
        @(posedge clk); #1;
        addr_ok = 1'b0; data_ok = 1'b0;
        #1 check("fw new load", load_data, 32'h1234_5678);
        check("fw done stall", {31'h0, stall_req}, 32'h0);
        @(posedge clk); #1;
        rmem = 1'b0;

        // Flush in REQ withdraws the request.
        rmem = 1'b1; op = 3'd4; addr = 32'h3008;
        @(posedge clk); #1;
        flush = 1'b1;
        #1 check("fr req", {31'h0, data_req}, 32'h1);
        @(posedge clk); #1;
        flush = 1'b0; rmem = 1'b0;
        #1 check("fr withdrawn", {31'h0, data_req}, 32'h0);
        check("fr no stall", {31'h0, stall_req}, 32'h0);

        // Reset asserted mid-transaction returns to IDLE at once.
        rmem = 1'b1; addr = 32'h40;
        @(posedge clk); #1;
        check("rst mid req", {31'h0, data_req}, 32'h1);
        rst_n = 1'b0; rmem = 1'b0;
        #1 check("rst mid drop", {31'h0, data_req}, 32'h0);
        check("rst mid load", load_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  r_op = 3'($urandom_range(0, 7));
            logic [31:0] r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((32'h1 << ref_size(r_op)) - 32'h1);
            run_access("rand", r_op, r_addr, $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), sc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
